// File: rtl/multiboot_pkg.sv
// multiboot_pkg: ICAPE2 IPROG command words, controller state enum, per-byte bit swap and word table
package multiboot_pkg;
  localparam logic [31:0] DUMMY = 32'hFFFF_FFFF;
  localparam logic [31:0] SYNC = 32'hAA99_5566;
  localparam logic [31:0] NOOP = 32'h2000_0000;
  localparam logic [31:0] WR_WBSTAR = 32'h3002_0001;
  localparam logic [31:0] WR_CMD = 32'h3000_8001;
  localparam logic [31:0] IPROG = 32'h0000_000F;
  typedef enum logic [2:0] {HOLDOFF, ARMED, PREP, SEQ, POST, DONE} state_t;
  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 8; i++)
        r[8*b+i] = w[8*b+7-i];
    return r;
  endfunction
  function automatic logic [31:0] iprog_word(input logic [2:0] idx, input logic [31:0] addr);
    case (idx)
      3'd0: return DUMMY;
      3'd1: return SYNC;
      3'd2: return NOOP;
      3'd3: return WR_WBSTAR;
      3'd4: return addr;
      3'd5: return WR_CMD;
      3'd6: return IPROG;
      default: return NOOP;
    endcase
  endfunction
endpackage

// File: rtl/multiboot_ctrl_if.sv
// multiboot_ctrl_if: boot request handshake (boot_req, slot_sel, req_err, busy) and ICAPE2 bus (icap_csib, icap_rdwrb, icap_data)
interface multiboot_ctrl_if #(parameter int SLOT_W = 1);
  logic boot_req;
  logic [SLOT_W-1:0] slot_sel;
  logic req_err;
  logic busy;
  logic icap_csib;
  logic icap_rdwrb;
  logic [31:0] icap_data;
  modport master(input boot_req, slot_sel, output req_err, busy, icap_csib, icap_rdwrb, icap_data);
  modport slave(output boot_req, slot_sel, input req_err, busy, icap_csib, icap_rdwrb, icap_data);
endinterface

// File: rtl/button_debounce.sv
// button_debounce: 2-flop sync + stability counter; in clk, reset, button; out level (debounced), rise (1-cycle, same cycle level flips 0->1)
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic level,
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic flip;
  assign flip = (sync[1] != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign rise = flip && !level;
  always_ff @(posedge clk)
    if (reset) begin
      sync <= '0;
      level <= 1'b0;
      cnt <= '0;
    end else begin
      sync <= {sync[0], button};
      if (flip) level <= !level;
      cnt <= (sync[1] == level || flip) ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/multiboot_ctrl.sv
// multiboot_ctrl: warm-boot controller issuing ICAPE2 IPROG; in clk, reset, boot_button, dfu_active, bus.boot_req/slot_sel; out bus.icap_*, bus.busy, bus.req_err, stay
module multiboot_ctrl
  import multiboot_pkg::*;
#(
  parameter int NUM_SLOTS = 2,
  parameter logic [NUM_SLOTS*32-1:0] SLOT_ADDRS = {32'h0010_0000, 32'h0000_0000},
  parameter int DEFAULT_SLOT = 1,
  parameter int HOLDOFF_CYCLES = 65535,
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic boot_button,
  input  logic dfu_active,
  multiboot_ctrl_if.master bus,
  output logic stay
);
  localparam int SLOT_W = NUM_SLOTS > 1 ? $clog2(NUM_SLOTS) : 1;
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [31:0] DEF_ADDR = SLOT_ADDRS[32*DEFAULT_SLOT +: 32];
  state_t state;
  logic [HW-1:0] hcnt;
  logic [2:0] idx;
  logic [31:0] addr;
  logic btn_level, btn_rise, valid, idle, accept;
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
    .clk(clk),
    .reset(reset),
    .button(boot_button),
    .level(btn_level),
    .rise(btn_rise)
  );
  assign valid = {1'b0, bus.slot_sel} < (SLOT_W + 1)'(NUM_SLOTS);
  assign idle = state == HOLDOFF || state == ARMED;
  // an explicit request (even an invalid one) pre-empts the auto-boot for that cycle
  assign accept = idle && (bus.boot_req ? valid : state == ARMED && !stay);
  always_ff @(posedge clk)
    if (reset) begin
      state <= HOLDOFF;
      hcnt <= '0;
      idx <= '0;
      addr <= '0;
      stay <= 1'b0;
      bus.busy <= 1'b0;
      bus.req_err <= 1'b0;
      bus.icap_csib <= 1'b1;
      bus.icap_rdwrb <= 1'b1;
      bus.icap_data <= '0;
    end else begin
      stay <= stay || (btn_rise && !btn_level) || dfu_active;
      bus.req_err <= bus.boot_req && !(idle && valid);
      case (state)
        HOLDOFF: begin
          hcnt <= hcnt + 1'b1;
          if (hcnt == HW'(HOLDOFF_CYCLES - 1)) state <= ARMED;
        end
        PREP: begin
          state <= SEQ;
          bus.icap_csib <= 1'b0;
          bus.icap_data <= byte_swap(iprog_word(3'd0, addr));
        end
        SEQ: begin
          idx <= idx + 3'd1;
          bus.icap_csib <= idx == 3'd7;
          bus.icap_data <= idx == 3'd7 ? '0 : byte_swap(iprog_word(idx + 3'd1, addr));
          if (idx == 3'd7) state <= POST;
        end
        POST: begin
          state <= DONE;
          bus.icap_rdwrb <= 1'b1;
        end
        default: ;
      endcase
      if (accept) begin
        state <= PREP;
        addr <= bus.boot_req ? SLOT_ADDRS[32*int'(bus.slot_sel) +: 32] : DEF_ADDR;
        bus.busy <= 1'b1;
        bus.icap_rdwrb <= 1'b0;
      end
    end
endmodule

// File: tb/tb_multiboot_ctrl.sv
// tb_multiboot_ctrl: randomized scenarios checked cycle-by-cycle against a timeline model of the boot controller
module tb_multiboot_ctrl;
  localparam int NS = 3;
  localparam int H = 48;
  localparam int D = 4;
  localparam int DEF = 1;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic boot_button = 1'b0;
  logic dfu_active = 1'b0;
  logic stay;
  multiboot_ctrl_if #(.SLOT_W(2)) bus();
  multiboot_ctrl #(
    .NUM_SLOTS(NS),
    .SLOT_ADDRS({32'h0040_0000, 32'h0010_0000, 32'h0000_0000}),
    .DEFAULT_SLOT(DEF),
    .HOLDOFF_CYCLES(H),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk),
    .reset(reset),
    .boot_button(boot_button),
    .dfu_active(dfu_active),
    .bus(bus),
    .stay(stay)
  );
  always #5 clk = ~clk;
  logic [31:0] words [8] = '{32'hFFFF_FFFF, 32'hAA99_5566, 32'h2000_0000, 32'h3002_0001,
                             32'h0, 32'h3000_8001, 32'h0000_000F, 32'h2000_0000};
  logic [31:0] slot_addr [3] = '{32'h0000_0000, 32'h0010_0000, 32'h0040_0000};
  int n_vec = 0, n_err = 0;
  int t, bt, press_at, dfu_at, run;
  bit booted, err_next;
  logic [31:0] maddr;
  function automatic logic [31:0] swp(input logic [31:0] w);
    logic [31:0] r;
    r = {<<{w}};
    return {<<8{r}};
  endfunction
  function automatic bit stay_vis(input int tt);
    return (dfu_at >= 0 && tt >= dfu_at + 1) || (press_at >= 0 && tt >= press_at + 3);
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d got %h exp %h", tag, t, got, exp);
    end
  endtask
  task automatic expect_outputs();
    int k;
    bit seq;
    logic [31:0] d;
    k = t - bt;
    seq = booted && k >= 2 && k <= 9;
    d = 32'h0;
    if (seq) d = swp(k == 6 ? maddr : words[k-2]);
    check("csib", 32'(bus.icap_csib), 32'(!seq));
    check("rdwrb", 32'(bus.icap_rdwrb), 32'(!(booted && k >= 1 && k <= 10)));
    check("data", bus.icap_data, d);
    check("busy", 32'(bus.busy), 32'(booted && k >= 1));
    check("stay", 32'(stay), 32'(stay_vis(t)));
    check("req_err", 32'(bus.req_err), 32'(err_next));
  endtask
  task automatic do_reset();
    boot_button = 1'b0;
    dfu_active = 1'b0;
    bus.boot_req = 1'b0;
    bus.slot_sel = 2'd0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    t = 0;
    bt = 0;
    booted = 1'b0;
    press_at = -1;
    dfu_at = -1;
    run = 0;
    err_next = 1'b0;
    expect_outputs();
    reset = 1'b0;
  endtask
  task automatic accept(input int s);
    booted = 1'b1;
    bt = t;
    maddr = slot_addr[s];
  endtask
  task automatic tick(input bit b, input bit dfu, input bit req, input logic [1:0] sel);
    boot_button = b;
    dfu_active = dfu;
    bus.boot_req = req;
    bus.slot_sel = sel;
    run = b ? run + 1 : 0;
    if (press_at < 0 && run >= D) press_at = t;
    if (dfu && dfu_at < 0) dfu_at = t;
    err_next = 1'b0;
    if (!booted) begin
      if (req) begin
        if (int'(sel) < NS) accept(int'(sel));
        else err_next = 1'b1;
      end else if (t >= H && !stay_vis(t)) accept(DEF);
    end else err_next = req;
    @(posedge clk);
    @(negedge clk);
    t++;
    expect_outputs();
  endtask
  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0, 1'b0, 2'd0);
  endtask
  initial begin
    bus.boot_req = 1'b0;
    bus.slot_sel = 2'd0;
    repeat (2) @(negedge clk);
    do_reset();
    idle(H + 15);
    do_reset();
    repeat (5) begin
      repeat ($urandom_range(1, D - 1)) tick(1'b1, 1'b0, 1'b0, 2'd0);
      repeat ($urandom_range(1, 2)) tick(1'b0, 1'b0, 1'b0, 2'd0);
    end
    repeat (D + 4) tick(1'b1, 1'b0, 1'b0, 2'd0);
    idle(10 * H - t);
    tick(1'b0, 1'b0, 1'b1, 2'd0);
    idle(14);
    do_reset();
    idle($urandom_range(2, 10));
    tick(1'b0, 1'b0, 1'b1, 2'd3);
    tick(1'b0, 1'b1, 1'b0, 2'd0);
    idle(5);
    tick(1'b0, 1'b0, 1'b1, 2'd2);
    idle(4);
    tick(1'b0, 1'b0, 1'b1, 2'd1);
    idle(12);
    do_reset();
    idle(H - 1);
    tick(1'b0, 1'b1, 1'b0, 2'd0);
    idle(30);
    do_reset();
    idle(H);
    tick(1'b0, 1'b0, 1'b1, 2'($urandom_range(0, 2)));
    idle(14);
    do_reset();
    idle(H + 5);
    do_reset();
    idle(H + 15);
    repeat (4) begin
      do_reset();
      repeat (H + 40)
        tick($urandom_range(0, 7) == 0 ? !boot_button : boot_button,
             $urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0,
             2'($urandom_range(0, 3)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
